// File: rtl/maxpool_sched.sv
`default_nettype none
// =============================================================================
// maxpool_sched : frame sequencer and result skid FIFO for the maxpooling unit
// Optional watchdog in DRAIN enabled by defining MP_SCHED_TIMEOUT_EN.
// Revision: 1.0
// =============================================================================
module maxpool_sched #(
    parameter int DW      = 8,
    parameter int DIMW    = 8,
    parameter int MP_LAT  = 2,
    parameter int FIFO_AW = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [DIMW-1:0] cfg_width,
    input  logic [DIMW-1:0] cfg_height,
    input  logic            cfg_pool,
    input  logic [DW-1:0]   s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [DW-1:0]   mp_in,
    output logic            mp_en,
    output logic            mp_en_mp,
    input  logic [DW-1:0]   mp_out,
    input  logic            mp_out_en,
    output logic [DW-1:0]   m_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int c_DEPTH = 1 << FIFO_AW;
    localparam int c_CW    = 2 * DIMW;
    localparam int c_IFW   = $clog2(MP_LAT + 1) + 1;
    localparam int c_CRW   = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_cfg_pool;
    logic [c_CW-1:0]   r_total;
    logic [c_CW-1:0]   r_expected;
    logic [c_CW-1:0]   r_in_cnt;
    logic [c_CW-1:0]   r_out_cnt;
    logic [c_IFW-1:0]  r_inflight;
    logic [DW-1:0]     r_mp_in;
    logic              r_mp_en;
    logic              r_err;

    logic [DW-1:0]     r_mem [c_DEPTH];
    logic [FIFO_AW:0]  r_wptr;
    logic [FIFO_AW:0]  r_rptr;
    logic [FIFO_AW:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    logic [c_CRW-1:0]  w_free;
    logic [c_CRW-1:0]  w_need;
    logic              w_credit_ok;
    logic [c_CW-1:0]   w_prod_full;
    logic [c_CW-1:0]   w_prod_pool;
    logic              w_cfg_ok;
    logic              w_start_take;
    logic              w_start_bad;
    logic              w_accept;
    logic              w_last_in;
    logic              w_out_idle;
    logic              w_out_excess;
    logic              w_overflow;
    logic              w_err_set;
    logic              w_wdog_fire;

    // ---------------------------------------------------------------- config
    assign w_cfg_ok     = (cfg_width != '0) && (cfg_height != '0) &&
                          !(cfg_pool && (cfg_width[0] || cfg_height[0]));
    assign w_start_take = start && (r_state == S_IDLE) && w_cfg_ok;
    // A start coinciding with the DONE cycle is silently dropped.
    assign w_start_bad  = start && (((r_state == S_IDLE) && !w_cfg_ok) ||
                                    (r_state == S_RUN) || (r_state == S_DRAIN));
    assign w_prod_full  = c_CW'(cfg_width) * c_CW'(cfg_height);
    assign w_prod_pool  = c_CW'(cfg_width >> 1) * c_CW'(cfg_height >> 1);

    // ---------------------------------------------------------------- credit
    // Accept only while the FIFO can absorb every result still in the pipe.
    assign w_free      = c_CRW'(c_DEPTH) - c_CRW'(w_count);
    assign w_need      = c_CRW'(MP_LAT) + c_CRW'(r_inflight);
    assign w_credit_ok = (w_free > w_need);
    assign w_accept    = (r_state == S_RUN) && s_valid && w_credit_ok;
    assign w_last_in   = w_accept && (r_in_cnt == (r_total - c_CW'(1)));

    // ---------------------------------------------------------------- errors
    assign w_out_idle   = mp_out_en && (r_state == S_IDLE);
    assign w_out_excess = mp_out_en && (r_state != S_IDLE) && (r_out_cnt >= r_expected);
    assign w_overflow   = mp_out_en && w_full;
    assign w_err_set    = w_start_bad | w_out_idle | w_out_excess | w_overflow | w_wdog_fire;

`ifdef MP_SCHED_TIMEOUT_EN
    logic [15:0] r_wdog;

    assign w_wdog_fire = (r_state == S_DRAIN) && (r_wdog == 16'hFFFF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog <= '0;
        end else if ((r_state != S_DRAIN) || mp_out_en) begin
            r_wdog <= '0;
        end else if (!w_wdog_fire) begin
            r_wdog <= r_wdog + 16'd1;
        end
    end
`else
    assign w_wdog_fire = 1'b0;
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        mp_en_mp    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_take) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy     = 1'b1;
                mp_en_mp = r_cfg_pool;
                s_ready  = w_credit_ok;
                if (w_last_in) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy     = 1'b1;
                mp_en_mp = r_cfg_pool;
                if ((r_out_cnt == r_expected) || w_wdog_fire) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cfg_pool <= 1'b0;
            r_total    <= '0;
            r_expected <= '0;
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
            r_inflight <= '0;
            r_mp_in    <= '0;
            r_mp_en    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_mp_en <= w_accept;
            if (w_accept) begin
                r_mp_in <= s_data;
            end
            r_err <= (r_err & ~w_start_take) | w_err_set;
            if (w_start_take) begin
                r_cfg_pool <= cfg_pool;
                r_total    <= w_prod_full;
                r_expected <= cfg_pool ? w_prod_pool : w_prod_full;
                r_in_cnt   <= '0;
                r_out_cnt  <= '0;
                r_inflight <= '0;
            end else begin
                if (w_accept) begin
                    r_in_cnt <= r_in_cnt + 1'b1;
                end
                if (mp_out_en) begin
                    r_out_cnt <= r_out_cnt + 1'b1;
                end
                // Pooling consumes four inputs per result, so this saturates high.
                case ({w_accept, mp_out_en})
                    2'b10: begin
                        if (r_inflight < c_IFW'(MP_LAT)) begin
                            r_inflight <= r_inflight + 1'b1;
                        end
                    end
                    2'b01: begin
                        if (r_inflight != '0) begin
                            r_inflight <= r_inflight - 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign mp_in = r_mp_in;
    assign mp_en = r_mp_en;
    assign err   = r_err;

    // ---------------------------------------------------------------- result FIFO
    assign w_count = r_wptr - r_rptr;
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                     (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
    assign w_push  = mp_out_en && !w_full;
    assign w_pop   = !w_empty && m_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[FIFO_AW-1:0]] <= mp_out;
        end
    end

    assign m_valid = !w_empty;
    assign m_data  = w_empty ? '0 : r_mem[r_rptr[FIFO_AW-1:0]];

endmodule
`default_nettype wire
